// File: rtl/mxu_result_drain.sv
// Result drain for the temporal MXU: snapshots the accumulator matrix, requantizes it
// and streams one row per valid/ready beat so the MXU can start its next pass early.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no frame held; waiting for a rising edge on out_valid
// STREAM | frame buffered; presenting rows 0..DIM-1 on the m_* beat port
module mxu_result_drain #(
    parameter int DIM           = 16,
    parameter int OUT_BIT_WIDTH = 8,
    parameter int RES_WIDTH     = 4,
    parameter int SHIFT_W       = 3,
    parameter int ROW_W         = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             out_valid,
    input  logic [DIM*DIM*OUT_BIT_WIDTH-1:0] out,
    input  logic [SHIFT_W-1:0]               shift,
    input  logic                             clear_overrun,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DIM*RES_WIDTH-1:0]         m_data,
    output logic [ROW_W-1:0]                 m_row,
    output logic                             m_last,
    output logic                             frame_done,
    output logic                             frame_sat,
    output logic                             busy,
    output logic                             overrun
);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM - 1);
    localparam logic signed [OUT_BIT_WIDTH-1:0] RES_MAX = OUT_BIT_WIDTH'(2 ** (RES_WIDTH - 1) - 1);
    localparam logic signed [OUT_BIT_WIDTH-1:0] RES_MIN = OUT_BIT_WIDTH'(-(2 ** (RES_WIDTH - 1)));

    state_t                            state_q, state_d;
    logic                              out_valid_q;
    logic [ROW_W-1:0]                  row_q, row_d;
    logic                              last_q, last_d;
    logic                              done_q, done_d;
    logic                              fsat_q, fsat_d;
    logic                              over_q, over_d;
    logic                              over_set;
    logic                              acc_q, acc_d;
    logic                              load;
    logic                              cap;
    logic                              row_sat;
    logic [SHIFT_W-1:0]                shift_q;
    logic signed [OUT_BIT_WIDTH-1:0]   buf_q [DIM][DIM];
    logic signed [OUT_BIT_WIDTH-1:0]   elem_x;
    logic signed [OUT_BIT_WIDTH-1:0]   elem_y;

    assign cap        = out_valid && !out_valid_q;
    assign m_valid    = (state_q == S_STREAM);
    assign busy       = (state_q == S_STREAM);
    assign m_row      = row_q;
    assign m_last     = last_q;
    assign frame_done = done_q;
    assign frame_sat  = fsat_q;
    assign overrun    = over_q;

    // Requantize the row currently selected by the row counter.
    always_comb begin
        m_data  = '0;
        row_sat = 1'b0;
        elem_x  = '0;
        elem_y  = '0;
        for (int c = 0; c < DIM; c++) begin
            elem_x = buf_q[row_q][c];
            elem_y = elem_x >>> shift_q;
            if (elem_y > RES_MAX) begin
                m_data[c*RES_WIDTH +: RES_WIDTH] = RES_MAX[RES_WIDTH-1:0];
                row_sat = 1'b1;
            end else if (elem_y < RES_MIN) begin
                m_data[c*RES_WIDTH +: RES_WIDTH] = RES_MIN[RES_WIDTH-1:0];
                row_sat = 1'b1;
            end else begin
                m_data[c*RES_WIDTH +: RES_WIDTH] = elem_y[RES_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        fsat_d   = 1'b0;
        over_set = 1'b0;
        load     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cap) begin
                    load    = 1'b1;
                    row_d   = '0;
                    acc_d   = 1'b0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (m_ready) begin
                    if (row_q == LAST_ROW) begin
                        done_d = 1'b1;
                        fsat_d = acc_q | row_sat;
                        row_d  = '0;
                        // A fresh edge on the final beat starts the next frame with no gap.
                        if (cap) begin
                            load  = 1'b1;
                            acc_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        row_d = row_q + ROW_W'(1);
                        acc_d = acc_q | row_sat;
                    end
                end
                if (cap && !(m_ready && (row_q == LAST_ROW))) begin
                    over_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        last_d = (state_d == S_STREAM) && (row_d == LAST_ROW);
        over_d = over_set || (over_q && !clear_overrun);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            row_q       <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            fsat_q      <= 1'b0;
            over_q      <= 1'b0;
            acc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid;
            row_q       <= row_d;
            last_q      <= last_d;
            done_q      <= done_d;
            fsat_q      <= fsat_d;
            over_q      <= over_d;
            acc_q       <= acc_d;
        end
    end

    // Frame buffer carries no reset; it is only read while a captured frame is live.
    always_ff @(posedge clk) begin
        if (load) begin
            shift_q <= shift;
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    buf_q[r][c] <= out[(r*DIM + c)*OUT_BIT_WIDTH +: OUT_BIT_WIDTH];
                end
            end
        end
    end

endmodule
